hazard_ctrl: RTL

//  Pipeline control unit that drives the en/clear pins of the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/hazard_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: turns memory wait states, multi-cycle MDU
// occupancy, taken branches and load-use hazards into en/clear actions for
// the PC and the four pipeline registers. It also keeps saturating counters
// of stall cycles and branch flushes.
module hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_tkn,
    input  logic             ex_mdu_op,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_clear,
    output logic             id_ex_en,
    output logic             id_ex_clear,
    output logic             ex_mem_en,
    output logic             ex_mem_clear,
    output logic             mem_wb_en,
    output logic             mem_wb_clear,
    output logic             mdu_last,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int MC_W = $clog2(MDU_LAT + 1);
    // The RUN cycle that sees ex_mdu_op is the first of MDU_LAT cycles and
    // the cycle with mdu_cnt=0 is the last, so the counter loads MDU_LAT-2.
    localparam logic [MC_W-1:0] MDU_LOAD = MC_W'(MDU_LAT - 2);

    typedef enum logic {RUN, MDU_BUSY} state_t;

    state_t            state_reg, state_next;
    logic [MC_W-1:0]   mdu_cnt_reg, mdu_cnt_next;
    logic              mem_wait;
    logic              mdu_active;
    logic              mdu_final;
    logic              load_use;
    logic [1:0]        cnt_inc;          // [0] stall, [1] flush
    logic [CNT_W-1:0]  perf_cnt_reg [2]; // [0] stall, [1] flush

    assign mem_wait   = mem_req && !mem_ready;
    assign mdu_active = ((state_reg == RUN) && ex_mdu_op) || (state_reg == MDU_BUSY);
    assign mdu_final  = (state_reg == MDU_BUSY) && (mdu_cnt_reg == '0);
    assign load_use   = ex_mem_read && (ex_rd != 5'd0) &&
                        ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                         (id_use_rs2 && (id_rs2 == ex_rd)));

    // Prioritised control decode plus MDU occupancy next-state.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_clear  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_clear  = 1'b0;
        ex_mem_en    = 1'b1;
        ex_mem_clear = 1'b0;
        mem_wb_en    = 1'b1;
        mem_wb_clear = 1'b0;
        mdu_last     = 1'b0;
        state_next   = state_reg;
        mdu_cnt_next = mdu_cnt_reg;
        cnt_inc      = 2'b00;

        if (rst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_clear  = 1'b1;
            id_ex_en     = 1'b0;
            id_ex_clear  = 1'b1;
            ex_mem_en    = 1'b0;
            ex_mem_clear = 1'b1;
            mem_wb_en    = 1'b0;
            mem_wb_clear = 1'b1;
        end else begin
            if (mem_wait) begin
                // Freeze everything up to MEM; WB gets a bubble. A pending
                // branch is picked up again once the freeze lifts.
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_en    = 1'b0;
                mem_wb_clear = 1'b1;
            end else if (mdu_active && !mdu_final) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_clear = 1'b1;
            end else if (mdu_final) begin
                mdu_last = 1'b1;
            end else if (ex_branch_tkn) begin
                if_id_clear = 1'b1;
                id_ex_clear = 1'b1;
                cnt_inc[1]  = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_clear = 1'b1;
            end

            cnt_inc[0] = !pc_en;

            // A memory freeze also freezes MDU progress.
            if (!mem_wait) begin
                case (state_reg)
                    RUN: begin
                        if (ex_mdu_op) begin
                            state_next   = MDU_BUSY;
                            mdu_cnt_next = MDU_LOAD;
                        end
                    end
                    MDU_BUSY: begin
                        if (mdu_cnt_reg != '0) begin
                            mdu_cnt_next = mdu_cnt_reg - 1'b1;
                        end else begin
                            state_next = RUN;
                        end
                    end
                    default: state_next = RUN;
                endcase
            end
        end
    end

    // MDU FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= RUN;
            mdu_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            mdu_cnt_reg <= mdu_cnt_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_perf
            // Saturating performance counter: sticks at all-ones.
            always_ff @(posedge clk) begin
                if (rst) begin
                    perf_cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (perf_cnt_reg[gi] != '1)) begin
                    perf_cnt_reg[gi] <= perf_cnt_reg[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign stall_cnt = perf_cnt_reg[0];
    assign flush_cnt = perf_cnt_reg[1];

    // An instruction cannot be both an MDU op and a taken branch.
    a_mdu_branch_excl: assert property (@(posedge clk) disable iff (rst)
        !(ex_mdu_op && ex_branch_tkn));

endmodule
